opc_io_uart: RTL and testbench

Byte-wide UART peripheral in the OPC5LS CPU's I/O space, sitting alongside the memory controller on the CPU bus. It decodes `vio` accesses to three word registers, serialises bytes from a 4-entry TX FIFO, and deserialises into a 4-entry RX FIFO. Read data goes to the top-level `cpu_din` mux; an active-low interrupt feeds one CPU `int_b` line.

---
 rtl/opc_uart_pkg.sv | 30 +++
 rtl/opc_uart_fifo.sv | 54 +++++
 rtl/opc_io_uart.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_opc_io_uart.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opc_uart_pkg.sv
// rtl/opc_uart_pkg.sv - shared constants and frame state type for opc_io_uart
//
// Purpose: register offsets, STATUS bit positions and the frame state enum
// used by both the transmitter and the receiver.
// Ports: none (package).
package opc_uart_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS bit positions
  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_TX_IDLE    = 3;
  localparam int ST_RX_IE      = 4;
  localparam int ST_TX_IE      = 5;
  localparam int ST_FRAME_ERR  = 6;

  // Frame state shared by TX and RX
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } frame_state_t;

endpackage

// File: rtl/opc_uart_fifo.sv
// rtl/opc_uart_fifo.sv - 8-bit synchronous FIFO used for the UART TX and RX queues
//
// Purpose: DEPTH-entry byte FIFO (DEPTH a power of 2, at least 2) with
// first-word-fall-through output. A push and a pop in the same cycle are both
// honoured even when the FIFO is full; a pop of an empty FIFO is ignored.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (empties the FIFO)
//   push, din    write strobe and byte
//   pop          read strobe; dout is the current head
//   empty, full  occupancy flags
module opc_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // On a full FIFO the slot being written is the one being popped this cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/opc_io_uart.sv
// rtl/opc_io_uart.sv - byte-wide UART peripheral in the OPC5LS I/O space
//
// Purpose: three word registers (DATA, STATUS, DIVISOR) at BASE_ADDR..+2, a
// TX FIFO feeding an 8N1 serialiser and an 8N1 deserialiser feeding an RX
// FIFO. Optional interrupt logic is built when OPC_UART_IRQ_EN is defined;
// otherwise int_b is tied high and rx_ie/tx_ie read as 0.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   vio, cpu_clken        I/O strobe and CPU clock enable (qualify side effects)
//   cpu_rnw, cpu_addr     1 = read, I/O word address
//   cpu_dout              write data
//   io_dout, io_sel       combinational read data and address-decode select
//   int_b                 registered active-low interrupt
//   uart_rx, uart_tx      serial input (asynchronous) and output (idle high)
module opc_io_uart #(
  parameter logic [15:0] BASE_ADDR  = 16'hFE08,
  parameter logic [15:0] DIV_RESET  = 16'd434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vio,
  input  logic        cpu_clken,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_dout,
  output logic [15:0] io_dout,
  output logic        io_sel,
  output logic        int_b,
  input  logic        uart_rx,
  output logic        uart_tx
);

  import opc_uart_pkg::*;

  // ---------------- bus decode ----------------
  logic [15:0] addr_off;
  logic [1:0]  reg_off;
  logic        acc;
  logic        bus_rd;
  logic        bus_wr;
  logic        tx_wr;
  logic        st_wr;
  logic        div_wr;

  // Modular subtraction keeps the range check correct for any BASE_ADDR.
  assign addr_off = cpu_addr - BASE_ADDR;
  assign io_sel   = vio & (addr_off < 16'd3);
  assign reg_off  = addr_off[1:0];
  assign acc      = vio & cpu_clken & io_sel;
  assign bus_rd   = acc & cpu_rnw;
  assign bus_wr   = acc & ~cpu_rnw;
  assign tx_wr    = bus_wr & (reg_off == REG_DATA);
  assign st_wr    = bus_wr & (reg_off == REG_STATUS);
  assign div_wr   = bus_wr & (reg_off == REG_DIV);

  // ---------------- registers ----------------
  logic [15:0] div;
  logic [15:0] period;
  logic [15:0] period_m1;
  logic [15:0] half_m1;
  logic        rx_overrun;
  logic        frame_err;
  logic        rx_overrun_set;
  logic        frame_err_set;
  logic        rx_ie;
  logic        tx_ie;

  assign period    = (div < 16'd2) ? 16'd2 : div;
  assign period_m1 = period - 16'd1;
  assign half_m1   = (period >> 1) - 16'd1;

  // A new event wins over a clear written in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div        <= DIV_RESET;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (div_wr) div <= cpu_dout;
      rx_overrun <= rx_overrun_set | (rx_overrun & ~(st_wr & cpu_dout[ST_RX_OVERRUN]));
      frame_err  <= frame_err_set  | (frame_err  & ~(st_wr & cpu_dout[ST_FRAME_ERR]));
    end
  end

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_empty, tx_full, tx_bypass;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;
  logic [7:0] rx_shift;

  assign tx_push = tx_wr & ~tx_bypass;
  assign rx_pop  = bus_rd & (reg_off == REG_DATA) & ~rx_empty;

  opc_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (cpu_dout[7:0]),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  opc_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // ---------------- transmitter ----------------
  frame_state_t tx_state, tx_state_n;
  logic [15:0]  tx_cnt, tx_cnt_n;
  logic [2:0]   tx_bit, tx_bit_n;
  logic [7:0]   tx_shift, tx_shift_n;
  logic         tx_line, tx_line_n;
  logic         tx_tick;
  logic         tx_idle;

  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_idle = tx_empty & (tx_state == IDLE);
  assign uart_tx = tx_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // The line level is registered alongside the state so it changes on the
  // same edge as the state. An IDLE write with an empty FIFO loads the
  // shifter directly so the start bit begins on the cycle after the write.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    tx_bypass  = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_state_n = START;
          tx_cnt_n   = period_m1;
          tx_line_n  = 1'b0;
        end else if (tx_wr) begin
          tx_bypass  = 1'b1;
          tx_shift_n = cpu_dout[7:0];
          tx_state_n = START;
          tx_cnt_n   = period_m1;
          tx_line_n  = 1'b0;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_state_n = DATA;
          tx_bit_n   = 3'd0;
          tx_cnt_n   = period_m1;
          tx_line_n  = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      DATA: begin
        if (tx_tick) begin
          tx_cnt_n = period_m1;
          if (tx_bit == 3'd7) begin
            tx_state_n = STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n  = tx_bit + 3'd1;
            tx_line_n = tx_shift[tx_bit + 3'd1];
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      STOP: begin
        if (tx_tick) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_state_n = START;
            tx_cnt_n   = period_m1;
            tx_line_n  = 1'b0;
          end else begin
            tx_state_n = IDLE;
            tx_line_n  = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  frame_state_t rx_state, rx_state_n;
  logic [15:0]  rx_cnt, rx_cnt_n;
  logic [2:0]   rx_bit, rx_bit_n;
  logic [7:0]   rx_shift_n;
  logic         rx_s1, rx_s2, rx_prev;
  logic         rx_tick;

  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Sampling is offset by half a bit from the detected falling edge so every
  // later sample lands mid-bit.
  always_comb begin
    rx_state_n     = rx_state;
    rx_cnt_n       = rx_cnt;
    rx_bit_n       = rx_bit;
    rx_shift_n     = rx_shift;
    rx_push        = 1'b0;
    rx_overrun_set = 1'b0;
    frame_err_set  = 1'b0;
    unique case (rx_state)
      IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = START;
          rx_cnt_n   = half_m1;
        end
      end
      START: begin
        if (rx_tick) begin
          if (rx_s2) begin
            rx_state_n = IDLE;
          end else begin
            rx_state_n = DATA;
            rx_bit_n   = 3'd0;
            rx_cnt_n   = period_m1;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      DATA: begin
        if (rx_tick) begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = period_m1;
          if (rx_bit == 3'd7) rx_state_n = STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      STOP: begin
        if (rx_tick) begin
          rx_state_n = IDLE;
          if (!rx_s2) begin
            frame_err_set = 1'b1;
          end else if (rx_full && !rx_pop) begin
            rx_overrun_set = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // ---------------- interrupt ----------------
`ifdef OPC_UART_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      int_b <= 1'b1;
    end else begin
      if (st_wr) begin
        rx_ie <= cpu_dout[ST_RX_IE];
        tx_ie <= cpu_dout[ST_TX_IE];
      end
      int_b <= ~((rx_ie & ~rx_empty) | (tx_ie & tx_idle));
    end
  end
`else
  assign rx_ie = 1'b0;
  assign tx_ie = 1'b0;
  assign int_b = 1'b1;
`endif

  // ---------------- read path ----------------
  logic [15:0] status;

  always_comb begin
    status                = 16'h0000;
    status[ST_RX_AVAIL]   = ~rx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_IDLE]    = tx_idle;
    status[ST_RX_IE]      = rx_ie;
    status[ST_TX_IE]      = tx_ie;
    status[ST_FRAME_ERR]  = frame_err;
  end

  always_comb begin
    io_dout = 16'h0000;
    if (io_sel) begin
      unique case (reg_off)
        REG_DATA:   io_dout = rx_empty ? 16'h0000 : {8'h00, rx_head};
        REG_STATUS: io_dout = status;
        REG_DIV:    io_dout = div;
        default:    io_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_opc_io_uart.sv
// tb/tb_opc_io_uart.sv - self-checking bench for opc_io_uart
module tb_opc_io_uart;

  localparam logic [15:0] BASE = 16'hFE08;
`ifdef OPC_UART_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [15:0] IE_MASK = IRQ ? 16'h0030 : 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vio = 1'b0;
  logic        cpu_clken = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] cpu_dout = 16'h0000;
  logic [15:0] io_dout;
  logic        io_sel;
  logic        int_b;
  logic        uart_rx;
  logic        uart_tx;
  logic        loop = 1'b0;
  logic        rx_drive = 1'b1;

  int checks = 0;
  int failures = 0;

  assign uart_rx = loop ? uart_tx : rx_drive;

  always #5 clk = ~clk;

  opc_io_uart dut (
    .clk       (clk),
    .reset     (reset),
    .vio       (vio),
    .cpu_clken (cpu_clken),
    .cpu_rnw   (cpu_rnw),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .io_dout   (io_dout),
    .io_sel    (io_sel),
    .int_b     (int_b),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [15:0] wdata;
    logic [15:0] exp;
    logic        exp_sel;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle with cpu_clken high: exactly one posedge sees the access.
  task automatic bus(input logic [15:0] a, input logic rnw, input logic [15:0] wd,
                     output logic [15:0] rd, output logic sel);
    @(negedge clk);
    vio = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_dout = wd; cpu_clken = 1'b1;
    #1;
    rd  = io_dout;
    sel = io_sel;
    @(negedge clk);
    vio = 1'b0; cpu_clken = 1'b0; cpu_rnw = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] r;
    logic s;
    bus(a, 1'b0, d, r, s);
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    logic s;
    bus(a, 1'b1, 16'h0000, d, s);
  endtask

  // Bench-driven 8N1 frame of p cycles per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drive = fr[k];
      repeat (p) @(negedge clk);
    end
    rx_drive = 1'b1;
  endtask

  initial begin
    vec_t        vecs [13];
    logic [15:0] r;
    logic        s;
    logic [9:0]  fr;
    logic [7:0]  q [$];
    logic [7:0]  bytes5 [5];

    vecs[0]  = '{BASE + 16'd1, 1'b1, 16'h0000, 16'h0008, 1'b1};
    vecs[1]  = '{BASE + 16'd2, 1'b1, 16'h0000, 16'h01B2, 1'b1};
    vecs[2]  = '{BASE,         1'b1, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{BASE + 16'd2, 1'b0, 16'h1234, 16'h0000, 1'b1};
    vecs[4]  = '{BASE + 16'd2, 1'b1, 16'h0000, 16'h1234, 1'b1};
    vecs[5]  = '{BASE + 16'd1, 1'b0, 16'h0030, 16'h0000, 1'b1};
    vecs[6]  = '{BASE + 16'd1, 1'b1, 16'h0000, 16'h0008 | IE_MASK, 1'b1};
    vecs[7]  = '{BASE + 16'd1, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{BASE + 16'd1, 1'b1, 16'h0000, 16'h0008, 1'b1};
    vecs[9]  = '{BASE + 16'd3, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{BASE - 16'd1, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{BASE + 16'd2, 1'b0, 16'h0004, 16'h0000, 1'b1};
    vecs[12] = '{BASE + 16'd2, 1'b1, 16'h0000, 16'h0004, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_uart_tx", {15'd0, uart_tx}, 16'd1);
    check("reset_int_b", {15'd0, int_b}, 16'd1);

    for (int i = 0; i < 13; i++) begin
      bus(vecs[i].addr, vecs[i].rnw, vecs[i].wdata, r, s);
      check($sformatf("vec%0d_sel", i), {15'd0, s}, {15'd0, vecs[i].exp_sel});
      if (vecs[i].rnw) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
    end

    // TX frame shape and latency at DIV=4
    fr = {1'b1, 8'hA5, 1'b0};
    wr(BASE, 16'h00A5);
    for (int c = 0; c < 40; c++) begin
      check($sformatf("tx_a5_cycle%0d", c), {15'd0, uart_tx}, {15'd0, fr[c / 4]});
      @(negedge clk);
    end
    rd(BASE + 16'd1, r);
    check("tx_idle_after_frame", r, 16'h0008);

    // Loopback single byte
    loop = 1'b1;
    wr(BASE, 16'h003C);
    repeat (50) @(negedge clk);
    rd(BASE + 16'd1, r);
    check("loop_status_avail", r, 16'h0009);
    rd(BASE, r);
    check("loop_data", r, 16'h003C);
    rd(BASE + 16'd1, r);
    check("loop_status_empty", r, 16'h0008);

    // Randomised loopback bursts against a queue model
    for (int it = 0; it < 6; it++) begin
      int d, p, n;
      logic [7:0] b;
      d = $urandom_range(0, 8);
      p = (d < 2) ? 2 : d;
      n = $urandom_range(1, 5);
      wr(BASE + 16'd2, 16'(d));
      q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        if (q.size() < 4) q.push_back(b);
        wr(BASE, {8'h00, b});
      end
      repeat ((n * 10 + 3) * p + 20) @(negedge clk);
      rd(BASE + 16'd1, r);
      check($sformatf("rand%0d_status", it), r, 16'h0009 | ((n > 4) ? 16'h0004 : 16'h0000));
      while (q.size() > 0) begin
        rd(BASE, r);
        check($sformatf("rand%0d_data", it), r, {8'h00, q.pop_front()});
      end
      rd(BASE, r);
      check($sformatf("rand%0d_empty_read", it), r, 16'h0000);
      wr(BASE + 16'd1, 16'h0004);
      rd(BASE + 16'd1, r);
      check($sformatf("rand%0d_cleared", it), r, 16'h0008);
    end
    loop = 1'b0;

    // Five frames with no reads: fifth byte dropped as overrun
    wr(BASE + 16'd2, 16'h0004);
    bytes5 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    for (int k = 0; k < 5; k++) send_frame(bytes5[k], 1'b1, 4);
    repeat (8) @(negedge clk);
    rd(BASE + 16'd1, r);
    check("overrun_status", r, 16'h000D);
    for (int k = 0; k < 4; k++) begin
      rd(BASE, r);
      check($sformatf("overrun_data%0d", k), r, {8'h00, bytes5[k]});
    end
    rd(BASE, r);
    check("overrun_fifth_dropped", r, 16'h0000);
    wr(BASE + 16'd1, 16'h0004);
    rd(BASE + 16'd1, r);
    check("overrun_cleared", r, 16'h0008);

    // Stop bit 0 -> frame error, no push
    send_frame(8'h55, 1'b0, 4);
    repeat (8) @(negedge clk);
    rd(BASE + 16'd1, r);
    check("frame_err_status", r, 16'h0048);
    wr(BASE + 16'd1, 16'h0040);
    rd(BASE + 16'd1, r);
    check("frame_err_cleared", r, 16'h0008);

    // One-cycle glitch -> false start
    @(negedge clk);
    rx_drive = 1'b0;
    @(negedge clk);
    rx_drive = 1'b1;
    repeat (20) @(negedge clk);
    rd(BASE + 16'd1, r);
    check("glitch_status", r, 16'h0008);

    // Stalled read: three cycles with cpu_clken low, one high -> one pop
    send_frame(8'h11, 1'b1, 4);
    send_frame(8'h22, 1'b1, 4);
    repeat (8) @(negedge clk);
    @(negedge clk);
    vio = 1'b1; cpu_rnw = 1'b1; cpu_addr = BASE; cpu_clken = 1'b0;
    repeat (3) @(negedge clk);
    cpu_clken = 1'b1;
    @(negedge clk);
    vio = 1'b0; cpu_clken = 1'b0;
    rd(BASE + 16'd1, r);
    check("stall_one_pop_status", r, 16'h0009);
    rd(BASE, r);
    check("stall_second_byte", r, 16'h0022);
    rd(BASE + 16'd1, r);
    check("stall_now_empty", r, 16'h0008);

    // Receive interrupt
    wr(BASE + 16'd1, 16'h0010);
    rd(BASE + 16'd1, r);
    check("rx_ie_readback", r, 16'h0008 | (16'h0010 & IE_MASK));
    send_frame(8'h5A, 1'b1, 4);
    repeat (8) @(negedge clk);
    check("irq_asserted", {15'd0, int_b}, {15'd0, ~IRQ});
    rd(BASE, r);
    check("irq_data", r, 16'h005A);
    check("irq_lag", {15'd0, int_b}, {15'd0, ~IRQ});
    @(negedge clk);
    check("irq_released", {15'd0, int_b}, 16'd1);

    // Reset in the middle of a TX frame with a pending RX interrupt
    send_frame(8'h77, 1'b1, 4);
    repeat (8) @(negedge clk);
    wr(BASE, 16'h0000);
    repeat (6) @(negedge clk);
    check("tx_mid_frame_low", {15'd0, uart_tx}, 16'd0);
    check("irq_before_reset", {15'd0, int_b}, {15'd0, ~IRQ});
    #1 reset = 1'b1;
    #1;
    check("reset_forces_tx_high", {15'd0, uart_tx}, 16'd1);
    check("reset_forces_int_b_high", {15'd0, int_b}, 16'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(BASE + 16'd1, r);
    check("post_reset_status", r, 16'h0008);
    rd(BASE + 16'd2, r);
    check("post_reset_div", r, 16'h01B2);
    rd(BASE, r);
    check("post_reset_data", r, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
